// File: rtl/load_store_unit_if.sv
// Data-memory req/ack port between the load/store unit (master) and memory (slave).
// Request fields are registered by the master and held stable until ack or abandonment.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store engine: min 3 cycles/access, 2 stall cycles with an ack in the first BUSY cycle.
// Backpressure: stalls the pipeline until mem_ack or WAIT_LIMIT; rejected accesses pulse misaligned without stalling.
module load_store_unit #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       write_data,
    load_store_unit_if.master mem,
    output logic [31:0]       memory_result,
    output logic              stall,
    output logic              misaligned,
    output logic              bus_timeout
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

    logic [1:0]  state;
    logic [7:0]  wait_cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        acc;
    logic        illegal;
    logic        start;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] lane;
    logic [31:0] load_val;

    // mem_write wins when both strobes are high, so stores use the store funct3 set
    always_comb begin
        illegal = 1'b0;
        if (mem_write) begin
            case (funct3)
                3'b000:  illegal = 1'b0;
                3'b001:  illegal = alu_result[0];
                3'b010:  illegal = |alu_result[1:0];
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b100: illegal = 1'b0;
                3'b001, 3'b101: illegal = alu_result[0];
                3'b010:         illegal = |alu_result[1:0];
                default:        illegal = 1'b1;
            endcase
        end
    end

    assign acc        = mem_read | mem_write;
    assign start      = !reset && (state == S_IDLE) && acc && !illegal;
    assign misaligned = !reset && (state == S_IDLE) && acc && illegal;
    assign stall      = start || (!reset && (state == S_BUSY));

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = write_data;
        if (mem_write) begin
            case (funct3[1:0])
                2'b00: begin
                    be_nxt    = 4'b0001 << alu_result[1:0];
                    wdata_nxt = {4{write_data[7:0]}};
                end
                2'b01: begin
                    be_nxt    = alu_result[1] ? 4'b1100 : 4'b0011;
                    wdata_nxt = {2{write_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // halfword offsets are always even here, so a byte-granular shift serves both widths
    always_comb begin
        lane = mem.mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_val = {24'h0, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_val = {16'h0, lane[15:0]};
            default: load_val = mem.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            wait_cnt      <= 8'd0;
            f3_q          <= 3'd0;
            off_q         <= 2'd0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'd0;
            mem.mem_be    <= 4'd0;
            mem.mem_wdata <= 32'd0;
            memory_result <= 32'd0;
            bus_timeout   <= 1'b0;
        end else begin
            bus_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= mem_write;
                        mem.mem_addr  <= {alu_result[31:2], 2'b00};
                        mem.mem_be    <= be_nxt;
                        mem.mem_wdata <= wdata_nxt;
                        f3_q          <= funct3;
                        off_q         <= alu_result[1:0];
                        wait_cnt      <= 8'd0;
                        state         <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        if (!mem.mem_we) memory_result <= load_val;
                        state <= S_DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        mem.mem_req <= 1'b0;
                        bus_timeout <= 1'b1;
                        if (!mem.mem_we) memory_result <= 32'd0;
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: transaction-level model plus per-cycle compare process.
module tb_load_store_unit;
    localparam int WL = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] alu_result = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] memory_result;
    logic        stall;
    logic        misaligned;
    logic        bus_timeout;

    load_store_unit_if mif ();

    load_store_unit #(.WAIT_LIMIT(WL)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .funct3        (funct3),
        .alu_result    (alu_result),
        .write_data    (write_data),
        .mem           (mif),
        .memory_result (memory_result),
        .stall         (stall),
        .misaligned    (misaligned),
        .bus_timeout   (bus_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model of the access currently presented to the unit
    logic        exp_we = 1'b0;
    logic        exp_is_load = 1'b0;
    logic        exp_legal = 1'b0;
    logic [2:0]  exp_f3 = 3'd0;
    logic [31:0] exp_addr = 32'd0;
    logic [31:0] exp_wd = 32'd0;
    logic [31:0] exp_mr = 32'd0;

    int          ack_delay = -1;
    logic [31:0] rdata_cfg = 32'd0;
    logic        force_late_ack = 1'b0;

    int          r_stalls;
    int          r_reqs;
    logic        r_mis;
    logic        r_to;
    logic [31:0] r_res;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sz(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic m_legal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        if (wr) begin
            if (f3 > 3'd2) return 1'b0;
        end else if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) begin
            return 1'b0;
        end
        return (int'(a[1:0]) % sz(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] be;
        int lo;
        if (!wr) return 4'hF;
        lo = int'(a[1:0]);
        for (int i = 0; i < 4; i++) be[i] = (i >= lo) && (i < lo + sz(f3));
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        longint v = 0;
        int lo = int'(a[1:0]);
        int n = sz(f3);
        for (int k = 0; k < n; k++) v += longint'(rd[8*(lo+k) +: 8]) << (8*k);
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8*n-1))) v -= (longint'(1) << (8*n));
        return 32'(v);
    endfunction

    task automatic set_exp(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        exp_we      = wr;
        exp_is_load = rd && !wr;
        exp_f3      = f3;
        exp_addr    = a;
        exp_wd      = wd;
        exp_legal   = m_legal(wr, f3, a);
    endtask

    // Called at posedge+1; holds the access until stall drops, then clears the strobes.
    task automatic do_acc(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdata, input int dly);
        logic done = 1'b0;
        set_exp(rd, wr, f3, a, wd);
        ack_delay  = dly;
        rdata_cfg  = rdata;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        alu_result = a;
        write_data = wd;
        r_stalls = 0; r_reqs = 0; r_mis = 1'b0; r_to = 1'b0;
        r_addr = 32'd0; r_be = 4'd0; r_wd = 32'd0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mif.mem_req) begin
                if (r_reqs == 0) begin
                    r_addr = mif.mem_addr; r_be = mif.mem_be; r_wd = mif.mem_wdata;
                end
                r_reqs++;
            end
            if (misaligned)  r_mis = 1'b1;
            if (bus_timeout) r_to = 1'b1;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            r_stalls++;
            @(posedge clk); #1;
        end
        chk("access_completes", 32'(done), 32'd1);
        r_res = memory_result;
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // memory responder: ack after ack_delay BUSY cycles, junk data when not acking
    initial begin
        int bc = 0;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 32'hBAD0BAD0;
        forever begin
            @(posedge clk); #2;
            if (mif.mem_req) begin
                if (ack_delay >= 0 && bc == ack_delay) begin
                    mif.mem_ack = 1'b1; mif.mem_rdata = rdata_cfg;
                end else begin
                    mif.mem_ack = 1'b0; mif.mem_rdata = 32'hBAD0BAD0;
                end
                bc++;
            end else begin
                bc = 0;
                mif.mem_ack   = force_late_ack;
                mif.mem_rdata = force_late_ack ? rdata_cfg : 32'hBAD0BAD0;
            end
        end
    end

    // per-cycle compare against the model
    initial begin
        logic        prev_req = 1'b0;
        logic        prev_ack = 1'b0;
        logic        rst_q = 1'b0;
        logic        done_now;
        logic [31:0] prev_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("stall_in_reset", 32'(stall), 32'd0);
                chk("misaligned_in_reset", 32'(misaligned), 32'd0);
            end
            if (rst_q) begin
                exp_mr = 32'd0;
                chk("after_reset_req", 32'(mif.mem_req), 32'd0);
                chk("after_reset_we", 32'(mif.mem_we), 32'd0);
                chk("after_reset_addr", mif.mem_addr, 32'd0);
                chk("after_reset_be", 32'(mif.mem_be), 32'd0);
                chk("after_reset_wdata", mif.mem_wdata, 32'd0);
                chk("after_reset_timeout", 32'(bus_timeout), 32'd0);
            end else begin
                done_now = prev_req && !mif.mem_req;
                if (done_now && exp_is_load)
                    exp_mr = prev_ack ? m_load(exp_f3, exp_addr, prev_rdata) : 32'd0;
                chk("bus_timeout", 32'(bus_timeout), 32'(done_now && !prev_ack));
            end
            chk("memory_result", memory_result, exp_mr);
            if (mif.mem_req) begin
                if (!reset) chk("stall_while_req", 32'(stall), 32'd1);
                chk("req_legal", 32'(exp_legal), 32'd1);
                chk("mem_addr", mif.mem_addr, {exp_addr[31:2], 2'b00});
                chk("mem_we", 32'(mif.mem_we), 32'(exp_we));
                chk("mem_be", 32'(mif.mem_be), 32'(m_be(exp_we, exp_f3, exp_addr)));
                if (exp_we) chk("mem_wdata", mif.mem_wdata, m_wdata(exp_f3, exp_wd));
            end
            prev_req   = mif.mem_req;
            prev_ack   = mif.mem_ack;
            prev_rdata = mif.mem_rdata;
            rst_q      = reset;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
    } bad_acc_t;
    bad_acc_t bad_tab[5] = '{
        '{1'b1, 1'b0, 3'b010, 32'h102},
        '{1'b0, 1'b1, 3'b001, 32'h201},
        '{1'b1, 1'b0, 3'b011, 32'h100},
        '{1'b0, 1'b1, 3'b100, 32'h100},
        '{1'b1, 1'b0, 3'b101, 32'h101}
    };

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_mem_req", 32'(mif.mem_req), 32'd0);
        chk("reset_memory_result", memory_result, 32'd0);
        chk("reset_bus_timeout", 32'(bus_timeout), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        do_acc(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0);
        chk("lw_stalls", r_stalls, 2);
        chk("lw_addr", r_addr, 32'h100);
        chk("lw_be", 32'(r_be), 32'hF);
        chk("lw_result", r_res, 32'hDEADBEEF);

        do_acc(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF0011, 1);
        chk("lb_result", r_res, 32'hFFFFFF80);
        chk("lb_stalls", r_stalls, 3);
        do_acc(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF0011, 2);
        chk("lbu_result", r_res, 32'h00000080);
        chk("lbu_stalls", r_stalls, 4);
        do_acc(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 32'h80FF0011, WL - 1);
        chk("lh_result", r_res, 32'hFFFF80FF);
        chk("lh_last_cycle_ack_no_timeout", 32'(r_to), 32'd0);
        chk("lh_stalls", r_stalls, WL + 1);
        do_acc(1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 32'h80FF0011, 0);
        chk("lhu_result", r_res, 32'h000080FF);

        do_acc(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, 32'd0, 0);
        chk("sb_be", 32'(r_be), 32'b0010);
        chk("sb_wdata", r_wd, 32'hABABABAB);
        chk("sb_result_unchanged", r_res, 32'h000080FF);
        do_acc(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234CDEF, 32'd0, 1);
        chk("sh_be", 32'(r_be), 32'b1100);
        chk("sh_wdata", r_wd, 32'hCDEFCDEF);
        do_acc(1'b1, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'd0, 0);
        chk("sw_be", 32'(r_be), 32'hF);
        chk("sw_wdata", r_wd, 32'hCAFEF00D);
        chk("sw_result_unchanged", r_res, 32'h000080FF);

        foreach (bad_tab[i]) begin
            do_acc(bad_tab[i].rd, bad_tab[i].wr, bad_tab[i].f3, bad_tab[i].a, 32'h11223344, 32'd0, -1);
            chk("reject_misaligned", 32'(r_mis), 32'd1);
            chk("reject_no_req", r_reqs, 0);
            chk("reject_no_stall", r_stalls, 0);
            chk("reject_result_unchanged", r_res, 32'h000080FF);
            @(negedge clk);
            chk("reject_pulse_one_cycle", 32'(misaligned), 32'd0);
            @(posedge clk); #1;
        end

        do_acc(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'h55555555, -1);
        chk("timeout_req_cycles", r_reqs, WL);
        chk("timeout_pulse", 32'(r_to), 32'd1);
        chk("timeout_result", r_res, 32'd0);
        chk("timeout_stalls", r_stalls, WL + 1);

        do_acc(1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 32'h12345678, 0);
        chk("pre_reset_load", r_res, 32'h12345678);

        set_exp(1'b1, 1'b0, 3'b010, 32'h500, 32'd0);
        ack_delay  = -1;
        mem_read   = 1'b1;
        funct3     = 3'b010;
        alu_result = 32'h500;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_req_still_busy", 32'(mif.mem_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        mem_read = 1'b0;
        rdata_cfg = 32'hFFFFFFFF;
        force_late_ack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("late_ack_req", 32'(mif.mem_req), 32'd0);
            chk("late_ack_stall", 32'(stall), 32'd0);
            chk("late_ack_result", memory_result, 32'd0);
        end
        @(posedge clk); #1;
        force_late_ack = 1'b0;

        do_acc(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 32'h0BADF00D, 1);
        chk("post_reset_load", r_res, 32'h0BADF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
